// File: rtl/zcash_aws_pkg.sv
// zcash_aws_pkg: shared word type, data width and input-state encoding for the AWS packet path
package zcash_aws_pkg;
  localparam int AWS_DAT_W = 64;
  typedef struct packed {
    logic                 eop;
    logic [2:0]           mod;
    logic [AWS_DAT_W-1:0] dat;
  } pkt_word_t;
  typedef enum logic {ACCEPT, DROP} in_state_t;
endpackage

// File: rtl/zcash_sdp_ram.sv
// zcash_sdp_ram: simple dual-port RAM (write port i_we/i_waddr/i_wdat, read port i_re/i_raddr -> o_rdat one cycle later, held until next read)
module zcash_sdp_ram #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 512
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdat,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdat
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdat;
  end
  always_ff @(posedge i_clk) begin
    if (i_re) o_rdat <= mem[i_raddr];
  end
endmodule

// File: rtl/zcash_aws_pkt_fifo.sv
// zcash_aws_pkt_fifo: store-and-forward packet FIFO (in: i_dat/i_val/o_rdy/i_eop/i_err/i_mod, out: o_dat/o_val/i_rdy/o_sop/o_eop/o_mod, stats: o_fill/o_pkt_fwd_cnt/o_pkt_drop_cnt)
module zcash_aws_pkt_fifo
  import zcash_aws_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [AWS_DAT_W-1:0]   i_dat,
  input  logic                   i_val,
  output logic                   o_rdy,
  input  logic                   i_eop,
  input  logic                   i_err,
  input  logic [2:0]             i_mod,
  output logic [AWS_DAT_W-1:0]   o_dat,
  output logic                   o_val,
  input  logic                   i_rdy,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic [2:0]             o_mod,
  output logic [$clog2(DEPTH):0] o_fill,
  output logic [CNT_W-1:0]       o_pkt_fwd_cnt,
  output logic [CNT_W-1:0]       o_pkt_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, used;
  in_state_t     st;
  pkt_word_t     wr_w, rd_w;
  logic          full, oversize, in_hs, we, re, ram_v, load;
  assign used     = wr_ptr - rd_ptr;
  assign full     = used == PW'(DEPTH);
  assign oversize = full && cmt_ptr == rd_ptr;
  assign o_rdy    = st == DROP || !full || oversize;
  assign in_hs    = i_val && o_rdy;
  assign we       = in_hs && st == ACCEPT && !full;
  assign wr_w     = '{eop: i_eop, mod: i_mod, dat: i_dat};
  assign load     = ram_v && (!o_val || i_rdy);
  assign re       = rd_ptr != cmt_ptr && (!ram_v || load);
  zcash_sdp_ram #(.WIDTH($bits(pkt_word_t)), .DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_waddr (wr_ptr[AW-1:0]),
    .i_wdat  (wr_w),
    .i_re    (re),
    .i_raddr (rd_ptr[AW-1:0]),
    .o_rdat  (rd_w)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st             <= ACCEPT;
      wr_ptr         <= '0;
      cmt_ptr        <= '0;
      rd_ptr         <= '0;
      ram_v          <= 1'b0;
      o_val          <= 1'b0;
      o_sop          <= 1'b1;
      o_eop          <= 1'b0;
      o_mod          <= '0;
      o_dat          <= '0;
      o_fill         <= '0;
      o_pkt_fwd_cnt  <= '0;
      o_pkt_drop_cnt <= '0;
    end else begin
      if (st == ACCEPT) begin
        if (oversize) begin
          wr_ptr         <= cmt_ptr;
          o_pkt_drop_cnt <= o_pkt_drop_cnt + 1'b1;
          st             <= (in_hs && i_eop) ? ACCEPT : DROP;
        end else if (in_hs && i_eop && i_err) begin
          wr_ptr         <= cmt_ptr;
          o_pkt_drop_cnt <= o_pkt_drop_cnt + 1'b1;
        end else if (in_hs) begin
          wr_ptr  <= wr_ptr + 1'b1;
          cmt_ptr <= i_eop ? wr_ptr + 1'b1 : cmt_ptr;
        end
      end else if (in_hs && i_eop) st <= ACCEPT;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      ram_v <= re || (ram_v && !load);
      o_val <= load || (o_val && !i_rdy);
      if (load) begin
        o_dat <= rd_w.dat;
        o_eop <= rd_w.eop;
        o_mod <= rd_w.mod;
      end
      if (o_val && i_rdy) begin
        o_sop         <= o_eop;
        o_pkt_fwd_cnt <= o_eop ? o_pkt_fwd_cnt + 1'b1 : o_pkt_fwd_cnt;
      end
      o_fill <= used;
    end
  end
endmodule

// File: tb/tb_zcash_aws_pkt_fifo.sv
// tb_zcash_aws_pkt_fifo: randomized scoreboard bench for the store-and-forward packet FIFO
module tb_zcash_aws_pkt_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  localparam int FW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [63:0] dat;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [63:0] i_dat, o_dat;
  logic i_val, o_rdy, i_eop, i_err, o_val, i_rdy, o_sop, o_eop;
  logic [2:0] i_mod, o_mod;
  logic [FW-1:0] o_fill;
  logic [CNT_W-1:0] o_pkt_fwd_cnt, o_pkt_drop_cnt;
  exp_t q[$];
  int checks = 0, errors = 0, exp_fwd = 0, exp_drop = 0, stalls = 0;
  bit rnd_rdy = 0, rdy_fix = 1;
  zcash_aws_pkt_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_dat(i_dat), .i_val(i_val), .o_rdy(o_rdy),
    .i_eop(i_eop), .i_err(i_err), .i_mod(i_mod), .o_dat(o_dat), .o_val(o_val),
    .i_rdy(i_rdy), .o_sop(o_sop), .o_eop(o_eop), .o_mod(o_mod), .o_fill(o_fill),
    .o_pkt_fwd_cnt(o_pkt_fwd_cnt), .o_pkt_drop_cnt(o_pkt_drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    i_rdy = 1;
    forever begin
      @(posedge clk);
      #2;
      i_rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : rdy_fix;
    end
  end
  initial begin
    exp_t e, prev;
    bit prev_hold = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_hold = 0;
      else begin
        if (prev_hold) begin
          check("hold_val", o_val, 1);
          check("hold_word", {o_eop, o_mod, o_dat}, {prev.eop, prev.mod, prev.dat});
        end
        if (o_val && i_rdy) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", {o_sop, o_eop, o_mod, o_dat});
          end else begin
            e = q.pop_front();
            check("out_word", {o_sop, o_eop, o_mod, o_dat}, e);
          end
        end
        prev_hold = o_val && !i_rdy;
        prev = '{sop: o_sop, eop: o_eop, mod: o_mod, dat: o_dat};
      end
    end
  end
  task automatic put_word(input exp_t w, input bit err, input bit rnd, input int maxw, output bit ok);
    int n = 0;
    if (rnd) while ($urandom_range(0, 3) == 0) begin
      i_val = 0;
      @(posedge clk);
      #1;
    end
    i_val = 1;
    i_dat = w.dat;
    i_eop = w.eop;
    i_mod = w.mod;
    i_err = w.eop ? err : 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!o_rdy && n < maxw) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    ok = o_rdy;
    if (ok) begin
      @(posedge clk);
      #1;
      i_val = 0;
    end
  endtask
  task automatic make_pkt(input int len, input int emod, output exp_t w[$]);
    w = {};
    for (int i = 0; i < len; i++)
      w.push_back('{sop: i == 0, eop: i == len - 1,
                    mod: (i == len - 1 && emod >= 0) ? 3'(emod) : 3'($urandom_range(0, 7)),
                    dat: {$urandom, $urandom}});
  endtask
  task automatic send_pkt(input int len, input bit err, input bit rnd, input int emod);
    exp_t w[$];
    bit ok;
    make_pkt(len, emod, w);
    if (!err && len <= DEPTH) begin
      foreach (w[i]) q.push_back(w[i]);
      exp_fwd++;
    end else exp_drop++;
    foreach (w[i]) begin
      put_word(w[i], err, rnd, 5000, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL in_timeout: got o_rdy=0 expected o_rdy=1 within 5000 cycles");
        @(posedge clk);
        #1;
        i_val = 0;
        return;
      end
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || o_val) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drain_empty", q.size(), 0);
    check("fwd_cnt", o_pkt_fwd_cnt, exp_fwd);
    check("drop_cnt", o_pkt_drop_cnt, exp_drop);
    check("fill_zero", o_fill, 0);
    @(posedge clk);
    #1;
  endtask
  task automatic reset_chk();
    check("rst_val", o_val, 0);
    check("rst_sop", o_sop, 1);
    check("rst_eop", o_eop, 0);
    check("rst_mod", o_mod, 0);
    check("rst_dat", o_dat, 0);
    check("rst_fill", o_fill, 0);
    check("rst_fwd", o_pkt_fwd_cnt, 0);
    check("rst_drop", o_pkt_drop_cnt, 0);
    check("rst_rdy", o_rdy, 1);
  endtask
  initial begin
    exp_t w[$];
    bit ok, stalled;
    int n, len;
    i_val = 0; i_dat = 0; i_eop = 0; i_err = 0; i_mod = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_chk();
    @(posedge clk);
    #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    send_pkt(3, 0, 0, 5);
    n = 1;
    @(negedge clk);
    while (!o_val && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 3);
    @(posedge clk);
    #1;
    drain();
    send_pkt(4, 1, 0, -1);
    send_pkt(2, 0, 0, -1);
    drain();
    rdy_fix = 0;
    repeat (2) @(posedge clk);
    #1;
    stalls = 0;
    send_pkt(20, 0, 0, -1);
    check("oversize_no_bp", stalls, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("oversize_no_out", o_val, 0);
    check("oversize_drop", o_pkt_drop_cnt, exp_drop);
    @(posedge clk);
    #1;
    send_pkt(2, 0, 0, -1);
    rdy_fix = 1;
    drain();
    rdy_fix = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) send_pkt(4, 0, 0, -1);
    make_pkt(4, -1, w);
    foreach (w[i]) q.push_back(w[i]);
    exp_fwd++;
    stalled = 0;
    foreach (w[i]) begin
      put_word(w[i], 0, 0, stalled ? 5000 : 10, ok);
      if (!ok && !stalled) begin
        stalled = 1;
        check("bp_rdy", o_rdy, 0);
        check("bp_fill", o_fill, DEPTH);
        check("bp_drop", o_pkt_drop_cnt, exp_drop);
        @(posedge clk);
        #1;
        rdy_fix = 1;
        put_word(w[i], 0, 0, 5000, ok);
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL bp_timeout: got o_rdy=0 expected o_rdy=1");
        @(posedge clk);
        #1;
        i_val = 0;
        break;
      end
    end
    check("bp_seen", stalled, 1);
    rdy_fix = 1;
    drain();
    rnd_rdy = 1;
    for (int p = 0; p < 1000; p++) begin
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(17, 40) : $urandom_range(1, 16);
      send_pkt(len, $urandom_range(0, 7) == 0, 1, -1);
    end
    drain();
    rnd_rdy = 0;
    rdy_fix = 0;
    repeat (2) @(posedge clk);
    #1;
    send_pkt(3, 0, 0, -1);
    send_pkt(3, 0, 0, -1);
    make_pkt(4, -1, w);
    put_word(w[0], 0, 0, 50, ok);
    put_word(w[1], 0, 0, 50, ok);
    rst = 1;
    q.delete();
    exp_fwd = 0;
    exp_drop = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    reset_chk();
    @(posedge clk);
    #1;
    rdy_fix = 1;
    send_pkt(5, 0, 0, 2);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
